// File: rtl/chimera_cluster_iso_ctrl.sv
// Cluster isolation controller: APB-programmed drain/gate/ungate sequencing per cluster domain.
// Define CHIMERA_ISO_TIMEOUT_EN to add the drain/release timeout counter with ERR/irq reporting.
module chimera_cluster_iso_ctrl #(
    parameter int unsigned NumClusters  = 5,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned TimeoutWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [11:0]            paddr_i,
    input  logic [31:0]            pwdata_i,
    input  logic [3:0]             pstrb_i,
    output logic [31:0]            prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic [NumClusters-1:0] iso_req_o,
    input  logic [NumClusters-1:0] iso_ack_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic                   busy_o,
    output logic                   irq_o
);

    localparam logic [2:0] ST_ACTIVE   = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_GATE     = 3'd2;
    localparam logic [2:0] ST_ISOLATED = 3'd3;
    localparam logic [2:0] ST_UNGATE   = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;

    localparam logic [11:0] ADDR_TARGET  = 12'h000;
    localparam logic [11:0] ADDR_STATUS  = 12'h004;
    localparam logic [11:0] ADDR_ERR     = 12'h008;
    localparam logic [11:0] ADDR_TIMEOUT = 12'h00C;

    localparam logic [7:0] SETTLE = 8'(SettleCycles);

    logic [2:0]             r_state   [NumClusters];
    logic [2:0]             w_state_d [NumClusters];
    logic [7:0]             r_cnt     [NumClusters];
    logic [7:0]             w_cnt_d   [NumClusters];
    logic [NumClusters-1:0] r_target;
    logic [NumClusters-1:0] w_iso;
    logic [NumClusters-1:0] w_trans;
    logic [NumClusters-1:0] w_err;
    logic [NumClusters-1:0] w_err_set;
    logic [NumClusters-1:0] w_tmo_hit;

    logic        w_access;
    logic        w_write;
    logic        w_mapped;
    logic        w_we_target;
    logic [31:0] w_wmask;
    logic [31:0] w_rdata;

    // Reset also blanks the APB response so a stray access during reset reads nothing.
    assign w_access    = psel_i & penable_i & ~rst_i;
    assign w_write     = w_access & pwrite_i & w_mapped;
    assign w_wmask     = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}}, {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
    assign w_we_target = w_write & (paddr_i == ADDR_TARGET);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_target <= '0;
        end else if (w_we_target) begin
            r_target <= (r_target & ~w_wmask[NumClusters-1:0]) |
                        (pwdata_i[NumClusters-1:0] & w_wmask[NumClusters-1:0]);
        end
    end

    always_comb begin
        w_err_set = '0;
        for (int i = 0; i < NumClusters; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            case (r_state[i])
                ST_ACTIVE: begin
                    if (r_target[i]) w_state_d[i] = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (iso_ack_i[i]) begin
                        w_state_d[i] = ST_GATE;
                        w_cnt_d[i]   = SETTLE;
                    end else if (w_tmo_hit[i]) begin
                        w_state_d[i] = ST_RELEASE;
                        w_err_set[i] = 1'b1;
                    end else if (!r_target[i]) begin
                        w_state_d[i] = ST_RELEASE;
                    end
                end
                ST_GATE: begin
                    w_cnt_d[i] = r_cnt[i] - 8'd1;
                    if (w_cnt_d[i] == 8'd0) w_state_d[i] = ST_ISOLATED;
                end
                ST_ISOLATED: begin
                    if (!r_target[i]) begin
                        w_state_d[i] = ST_UNGATE;
                        w_cnt_d[i]   = SETTLE;
                    end
                end
                ST_UNGATE: begin
                    w_cnt_d[i] = r_cnt[i] - 8'd1;
                    if (w_cnt_d[i] == 8'd0) w_state_d[i] = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!iso_ack_i[i]) begin
                        w_state_d[i] = ST_ACTIVE;
                    end else if (w_tmo_hit[i]) begin
                        w_state_d[i] = ST_ACTIVE;
                        w_err_set[i] = 1'b1;
                    end
                end
                default: w_state_d[i] = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumClusters; i++) begin
            if (rst_i) begin
                r_state[i] <= ST_ACTIVE;
                r_cnt[i]   <= '0;
            end else begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
            end
        end
    end

    always_comb begin
        w_iso     = '0;
        w_trans   = '0;
        iso_req_o = '0;
        clk_en_o  = '0;
        for (int i = 0; i < NumClusters; i++) begin
            w_iso[i]     = (r_state[i] == ST_ISOLATED);
            w_trans[i]   = (r_state[i] != ST_ACTIVE) && (r_state[i] != ST_ISOLATED);
            iso_req_o[i] = (r_state[i] != ST_ACTIVE) && (r_state[i] != ST_RELEASE);
            clk_en_o[i]  = (r_state[i] != ST_GATE) && (r_state[i] != ST_ISOLATED);
        end
    end

`ifdef CHIMERA_ISO_TIMEOUT_EN
    logic [TimeoutWidth-1:0] r_timeout;
    logic [TimeoutWidth-1:0] r_tmo [NumClusters];
    logic [NumClusters-1:0]  r_err;
    logic [NumClusters-1:0]  w_err_clr;
    logic                    w_we_err;
    logic                    w_we_tmo;
    logic                    w_unused;

    assign w_we_err  = w_write & (paddr_i == ADDR_ERR);
    assign w_we_tmo  = w_write & (paddr_i == ADDR_TIMEOUT);
    assign w_err_clr = w_we_err ? (pwdata_i[NumClusters-1:0] & w_wmask[NumClusters-1:0]) : '0;
    assign w_err     = r_err;
    assign w_unused  = ^{pwdata_i, w_wmask};

    always_comb begin
        w_tmo_hit = '0;
        for (int i = 0; i < NumClusters; i++) begin
            w_tmo_hit[i] = ((r_state[i] == ST_DRAIN) || (r_state[i] == ST_RELEASE)) &&
                           ((r_tmo[i] + TimeoutWidth'(1)) >= r_timeout);
        end
    end

    // Counter restarts on every entry to DRAIN/RELEASE; a timeout set beats a same-cycle W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= '1;
            r_err     <= '0;
            for (int i = 0; i < NumClusters; i++) r_tmo[i] <= '0;
        end else begin
            if (w_we_tmo) begin
                r_timeout <= (r_timeout & ~w_wmask[TimeoutWidth-1:0]) |
                             (pwdata_i[TimeoutWidth-1:0] & w_wmask[TimeoutWidth-1:0]);
            end
            r_err <= (r_err & ~w_err_clr) | w_err_set;
            for (int i = 0; i < NumClusters; i++) begin
                if ((w_state_d[i] == r_state[i]) &&
                    ((r_state[i] == ST_DRAIN) || (r_state[i] == ST_RELEASE))) begin
                    r_tmo[i] <= r_tmo[i] + TimeoutWidth'(1);
                end else begin
                    r_tmo[i] <= '0;
                end
            end
        end
    end
`else
    logic w_unused;

    assign w_tmo_hit = '0;
    assign w_err     = '0;
    assign w_unused  = ^{pwdata_i, w_wmask, w_err_set};
`endif

    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (paddr_i)
            ADDR_TARGET: w_rdata[NumClusters-1:0] = r_target;
            ADDR_STATUS: begin
                w_rdata[NumClusters-1:0]  = w_iso;
                w_rdata[16 +: NumClusters] = w_trans;
            end
            ADDR_ERR:    w_rdata[NumClusters-1:0] = w_err;
`ifdef CHIMERA_ISO_TIMEOUT_EN
            ADDR_TIMEOUT: w_rdata[TimeoutWidth-1:0] = r_timeout;
`endif
            default:     w_mapped = 1'b0;
        endcase
    end

    assign prdata_o  = w_access ? w_rdata : '0;
    assign pslverr_o = w_access & ~w_mapped;
    assign pready_o  = 1'b1;
    assign busy_o    = |w_trans;
    assign irq_o     = |w_err;

endmodule

// File: tb/tb_chimera_cluster_iso_ctrl.sv
// Bench for chimera_cluster_iso_ctrl: APB vector table, directed sequences, random traffic
// checked every cycle against a phase-level reference model.
module tb_chimera_cluster_iso_ctrl;

    localparam int N  = 5;
    localparam int S  = 4;
    localparam int VW = 2 * N + 4 + 32;
`ifdef CHIMERA_ISO_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [N-1:0] iso_ack = '0;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o, busy_o, irq_o;
    logic [N-1:0] iso_req_o, clk_en_o;

    chimera_cluster_iso_ctrl #(
        .NumClusters (N),
        .SettleCycles(S),
        .TimeoutWidth(16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .pstrb_i  (pstrb),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .iso_req_o(iso_req_o),
        .iso_ack_i(iso_ack),
        .clk_en_o (clk_en_o),
        .busy_o   (busy_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] s_rd;
    logic        s_err;
    bit          clk0_low_seen;

    // Reference model: each cluster is a named phase plus a settle countdown and a
    // count of cycles spent waiting in DRAIN/RELEASE.
    string        m_ph   [N];
    int           m_cnt  [N];
    int           m_wait [N];
    logic [N-1:0] m_target, m_err;
    logic [31:0]  m_timeout;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ph[i] = "ACTIVE"; m_cnt[i] = 0; m_wait[i] = 0;
        end
        m_target = '0; m_err = '0; m_timeout = 32'h0000_FFFF;
    endtask

    task automatic model_advance();
        logic [31:0]  mask;
        logic [N-1:0] set, clr;
        string        nph;
        bit           hit;
        if (rst) begin
            model_reset();
            return;
        end
        set = '0; clr = '0;
        for (int i = 0; i < N; i++) begin
            nph = m_ph[i];
            hit = TMO && ((m_wait[i] + 1) >= int'(m_timeout));
            case (m_ph[i])
                "ACTIVE":   if (m_target[i]) nph = "DRAIN";
                "DRAIN": begin
                    if (iso_ack[i]) begin nph = "GATE"; m_cnt[i] = S; end
                    else if (hit) begin nph = "RELEASE"; set[i] = 1'b1; end
                    else if (!m_target[i]) nph = "RELEASE";
                end
                "GATE": begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) nph = "ISOLATED";
                end
                "ISOLATED": if (!m_target[i]) begin nph = "UNGATE"; m_cnt[i] = S; end
                "UNGATE": begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) nph = "RELEASE";
                end
                "RELEASE": begin
                    if (!iso_ack[i]) nph = "ACTIVE";
                    else if (hit) begin nph = "ACTIVE"; set[i] = 1'b1; end
                end
                default: nph = "ACTIVE";
            endcase
            if (nph == m_ph[i] && (nph == "DRAIN" || nph == "RELEASE")) m_wait[i]++;
            else m_wait[i] = 0;
            m_ph[i] = nph;
        end
        mask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
        if (psel && penable && pwrite) begin
            if (paddr == 12'h000) m_target = (m_target & ~mask[N-1:0]) | (pwdata[N-1:0] & mask[N-1:0]);
            if (paddr == 12'h008) clr = pwdata[N-1:0] & mask[N-1:0];
            if (paddr == 12'h00C && TMO) m_timeout = ((m_timeout & ~mask) | (pwdata & mask)) & 32'h0000_FFFF;
        end
        m_err = TMO ? ((m_err & ~clr) | set) : '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every output with the model, then advance model and clock to the next negedge.
    task automatic step();
        logic [N-1:0] e_iso, e_clk, e_isol, e_trans;
        logic [31:0]  e_rd;
        logic         e_slv;
        logic [VW-1:0] a_v, e_v;
        #1;
        e_rd = '0; e_slv = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_isol[i]  = (m_ph[i] == "ISOLATED");
            e_trans[i] = (m_ph[i] != "ACTIVE") && (m_ph[i] != "ISOLATED");
            e_iso[i]   = (m_ph[i] != "ACTIVE") && (m_ph[i] != "RELEASE");
            e_clk[i]   = (m_ph[i] != "GATE") && (m_ph[i] != "ISOLATED");
        end
        if (psel && penable && !rst) begin
            case (paddr)
                12'h000: e_rd[N-1:0] = m_target;
                12'h004: begin e_rd[N-1:0] = e_isol; e_rd[16 +: N] = e_trans; end
                12'h008: e_rd[N-1:0] = m_err;
                12'h00C: if (TMO) e_rd = m_timeout; else e_slv = 1'b1;
                default: e_slv = 1'b1;
            endcase
        end
        e_v = {e_iso, e_clk, |e_trans, |m_err, e_slv, 1'b1, e_rd};
        a_v = {iso_req_o, clk_en_o, busy_o, irq_o, pslverr_o, pready_o, prdata_o};
        n_vec++;
        if (a_v !== e_v) begin
            n_err++;
            $display("FAIL model cycle %0d: {iso,clk,busy,irq,slverr,rdy,rdata} got %h want %h",
                     cyc, a_v, e_v);
        end
        s_rd = prdata_o; s_err = pslverr_o;
        if (clk_en_o[0] !== 1'b1) clk0_low_seen = 1'b1;
        model_advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        step();
        penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    typedef struct {
        int          gap;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } apb_vec_t;

    apb_vec_t tbl[$];
    int       cnt;
    int       r;
    logic [11:0] ra;

    initial begin
        tbl.push_back('{0, 1'b0, 12'h000, 32'h0,         4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h004, 32'h0,         4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h008, 32'h0,         4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h010, 32'h0,         4'hF, 32'h0,         1'b1});
        tbl.push_back('{0, 1'b0, 12'h00C, 32'h0,         4'hF,
                        TMO ? 32'h0000_FFFF : 32'h0, !TMO});
        tbl.push_back('{0, 1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h000, 32'h0,         4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b1, 12'h000, 32'h0000_0015, 4'h1, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b1, 12'h000, 32'h0000_0000, 4'hE, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h000, 32'h0,         4'hF, 32'h0000_0015, 1'b0});
        tbl.push_back('{0, 1'b1, 12'h004, 32'h0000_001F, 4'hF, 32'h0,         1'b0});
        tbl.push_back('{2, 1'b0, 12'h004, 32'h0,         4'hF, 32'h0015_0000, 1'b0});
        tbl.push_back('{0, 1'b1, 12'h010, 32'h1234_5678, 4'hF, 32'h0,         1'b1});
        tbl.push_back('{0, 1'b1, 12'h000, 32'h0,         4'h1, 32'h0,         1'b0});
        tbl.push_back('{4, 1'b0, 12'h004, 32'h0,         4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b1, 12'h008, 32'h0000_001F, 4'hF, 32'h0,         1'b0});
        tbl.push_back('{0, 1'b0, 12'h008, 32'h0,         4'hF, 32'h0,         1'b0});

        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("reset iso_req", 32'(iso_req_o), 32'h0);
        chk("reset clk_en", 32'(clk_en_o), 32'h1F);
        chk("reset busy/irq/slverr", {29'b0, busy_o, irq_o, pslverr_o}, 32'h0);
        chk("reset prdata", prdata_o, 32'h0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            repeat (tbl[k].gap) step();
            apb_xfer(tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].strb);
            chk($sformatf("tbl%0d pslverr", k), {31'b0, s_err}, {31'b0, tbl[k].exp_err});
            if (!tbl[k].wr) chk($sformatf("tbl%0d prdata", k), s_rd, tbl[k].exp_rd);
        end

        // Isolate cluster 0 with a late ack.
        apb_xfer(1'b1, 12'h000, 32'h1, 4'hF);
        for (int k = 0; k < 10 && iso_req_o[0] !== 1'b1; k++) step();
        chk("iso0 iso_req rise", 32'(iso_req_o[0]), 32'h1);
        step(); step();
        iso_ack[0] = 1'b1;
        chk("iso0 clk_en before ack", 32'(clk_en_o[0]), 32'h1);
        step();
        for (int k = 0; k < S; k++) begin
            chk($sformatf("iso0 gate%0d clk_en/busy", k), {30'b0, clk_en_o[0], busy_o}, 32'h1);
            step();
        end
        chk("iso0 busy done", 32'(busy_o), 32'h0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'hF);
        chk("iso0 status", s_rd, 32'h1);

        // Release cluster 0, ack dropped two cycles after iso_req falls.
        apb_xfer(1'b1, 12'h000, 32'h0, 4'hF);
        for (int k = 0; k < 10 && clk_en_o[0] !== 1'b1; k++) step();
        chk("rel0 clk_en rise", 32'(clk_en_o[0]), 32'h1);
        cnt = 0;
        for (int k = 0; k < 12 && iso_req_o[0] === 1'b1; k++) begin
            if (clk_en_o[0] === 1'b1) cnt++;
            step();
        end
        chk("rel0 ungate cycles", cnt, S);
        step(); step();
        chk("rel0 busy in release", 32'(busy_o), 32'h1);
        iso_ack[0] = 1'b0;
        step();
        chk("rel0 busy/iso_req after", {30'b0, busy_o, iso_req_o[0]}, 32'h0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'hF);
        chk("rel0 status", s_rd, 32'h0);

        // Abort a drain before any ack.
        clk0_low_seen = 1'b0;
        apb_xfer(1'b1, 12'h000, 32'h1, 4'hF);
        for (int k = 0; k < 10 && iso_req_o[0] !== 1'b1; k++) step();
        chk("abort iso_req rise", 32'(iso_req_o[0]), 32'h1);
        step(); step();
        apb_xfer(1'b1, 12'h000, 32'h0, 4'hF);
        for (int k = 0; k < 20 && busy_o !== 1'b0; k++) step();
        chk("abort busy idle", 32'(busy_o), 32'h0);
        chk("abort iso_req low", 32'(iso_req_o[0]), 32'h0);
        chk("abort clk_en never low", 32'(clk0_low_seen), 32'h0);

        // Reset while every cluster is gating.
        apb_xfer(1'b1, 12'h000, 32'h1F, 4'hF);
        for (int k = 0; k < 10 && iso_req_o !== 5'h1F; k++) step();
        chk("rstgate iso_req all", 32'(iso_req_o), 32'h1F);
        iso_ack = 5'h1F;
        step();
        chk("rstgate clk_en gated", 32'(clk_en_o), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstgate iso_req", 32'(iso_req_o), 32'h0);
        chk("rstgate clk_en", 32'(clk_en_o), 32'h1F);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'hF);
        chk("rstgate target", s_rd, 32'h0);
        iso_ack = '0;
        step();

`ifdef CHIMERA_ISO_TIMEOUT_EN
        // Cluster 0 times out in DRAIN, cluster 1 isolates normally.
        apb_xfer(1'b1, 12'h00C, 32'd10, 4'hF);
        iso_ack = 5'h02;
        apb_xfer(1'b1, 12'h000, 32'h3, 4'hF);
        for (int k = 0; k < 40 && irq_o !== 1'b1; k++) step();
        chk("tmo irq", 32'(irq_o), 32'h1);
        apb_xfer(1'b1, 12'h000, 32'h2, 4'hF);
        repeat (6) step();
        apb_xfer(1'b0, 12'h008, 32'h0, 4'hF);
        chk("tmo err", s_rd, 32'h1);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'hF);
        chk("tmo status", s_rd, 32'h2);
        apb_xfer(1'b1, 12'h008, 32'h1, 4'hF);
        chk("tmo irq cleared", 32'(irq_o), 32'h0);
`endif

        // Random traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) iso_ack[i] = ~iso_ack[i];
            r = $urandom_range(99);
            if (r < 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (r < 12) begin
                apb_xfer(1'b1, 12'h000, $urandom, 4'($urandom_range(15)));
            end else if (r < 20) begin
                case ($urandom_range(5))
                    0: ra = 12'h000;
                    1: ra = 12'h004;
                    2: ra = 12'h008;
                    3: ra = 12'h00C;
                    4: ra = 12'h010;
                    default: ra = 12'($urandom);
                endcase
                apb_xfer(1'b0, ra, 32'h0, 4'hF);
            end else if (r < 23) begin
                apb_xfer(1'b1, 12'h008, $urandom, 4'hF);
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
